// File: rtl/posit_quire_accum.sv
// Exact posit dot-product accumulator: aligns decoded products into a wide fixed-point quire, normalises on last.
// Latency: last accepted at T -> out_valid at T+4; one term/cycle; in_ready low from last-accept until result consumed.
// Backpressure: result held stable while out_valid & !out_ready; new sum accepted the cycle after the handshake.
module posit_quire_accum #(
  parameter int NBITS  = 32,
  parameter int ES     = 2,
  parameter int FBITS  = NBITS - 3 - ES,
  parameter int MBITS  = 2 * (FBITS + 1),
  parameter int MAXS   = (1 << ES) * (NBITS - 2),
  parameter int CARRY  = 8,
  parameter int QFRAC  = 2 * MAXS + MBITS,
  parameter int QBITS  = QFRAC + 2 * MAXS + 2 + CARRY + 1,
  parameter int OFBITS = FBITS + 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic              in_sign,
  input  logic [8:0]        in_scale,
  input  logic [MBITS-1:0]  in_fraction,
  input  logic              in_inf,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [9:0]        out_scale,
  output logic [OFBITS-1:0] out_fraction,
  output logic              out_inf,
  output logic              out_zero
);

  typedef enum logic [1:0] {ACCUM, DRAIN, NORM, OUT} state_t;

  state_t           state;
  logic             started;
  logic             drain_cnt;
  logic             term_vld;
  logic             nar;
  logic [QBITS-1:0] term_q;
  logic [QBITS-1:0] acc;
  logic             accept;

  assign in_ready = started && (state == ACCUM);
  assign accept   = in_valid && in_ready && !clear;

  // Stage-1 alignment: in_fraction bit MBITS-2 carries weight 2^in_scale.
  int               shamt;
  logic [QBITS-1:0] wide;
  logic [QBITS-1:0] term_mag;
  logic [QBITS-1:0] term_d;

  always_comb begin
    shamt = int'($signed(in_scale)) + QFRAC - (MBITS - 2);
    wide  = {{(QBITS-MBITS){1'b0}}, in_fraction};
    if (shamt >= 0) term_mag = wide << shamt;
    else            term_mag = wide >> (-shamt);
    term_d = in_sign ? (~term_mag + 1'b1) : term_mag;
    if (in_zero || in_inf) term_d = '0;
  end

  logic              acc_neg;
  logic [QBITS-1:0]  mag;
  logic [QBITS-1:0]  norm;
  int                lead;
  logic              ovf;
  logic [9:0]        scale_d;
  logic [OFBITS-1:0] frac_d;

  always_comb begin
    acc_neg = acc[QBITS-1];
    mag     = acc_neg ? (~acc + 1'b1) : acc;
    lead    = 0;
    for (int i = 0; i < QBITS; i++) begin
      if (mag[i]) lead = i;
    end
    // Leading one moves to the MSB; the OFBITS bits beneath it are the fraction.
    norm    = mag << (QBITS - 1 - lead);
    frac_d  = OFBITS'(norm >> (QBITS - 1 - OFBITS));
    scale_d = 10'(lead - QFRAC);
    ovf     = (acc[QBITS-1 -: CARRY+1] != {(CARRY+1){acc_neg}});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ACCUM;
      started      <= 1'b0;
      drain_cnt    <= 1'b0;
      term_vld     <= 1'b0;
      term_q       <= '0;
      acc          <= '0;
      nar          <= 1'b0;
      out_valid    <= 1'b0;
      out_sign     <= 1'b0;
      out_scale    <= '0;
      out_fraction <= '0;
      out_inf      <= 1'b0;
      out_zero     <= 1'b0;
    end else begin
      started <= 1'b1;
      if (clear) begin
        state        <= ACCUM;
        drain_cnt    <= 1'b0;
        term_vld     <= 1'b0;
        acc          <= '0;
        nar          <= 1'b0;
        out_valid    <= 1'b0;
        out_sign     <= 1'b0;
        out_scale    <= '0;
        out_fraction <= '0;
        out_inf      <= 1'b0;
        out_zero     <= 1'b0;
      end else begin
        term_vld <= accept;
        if (accept) begin
          term_q <= term_d;
          if (in_inf) nar <= 1'b1;
        end
        if (term_vld) acc <= acc + term_q;

        case (state)
          ACCUM: begin
            if (accept && in_last) begin
              state     <= DRAIN;
              drain_cnt <= 1'b0;
            end
          end
          DRAIN: begin
            drain_cnt <= 1'b1;
            if (drain_cnt) state <= NORM;
          end
          NORM: begin
            out_valid <= 1'b1;
            state     <= OUT;
            if (nar || ovf) begin
              out_inf      <= 1'b1;
              out_zero     <= 1'b0;
              out_sign     <= 1'b0;
              out_scale    <= '0;
              out_fraction <= '0;
            end else if (mag == '0) begin
              out_inf      <= 1'b0;
              out_zero     <= 1'b1;
              out_sign     <= 1'b0;
              out_scale    <= '0;
              out_fraction <= '0;
            end else begin
              out_inf      <= 1'b0;
              out_zero     <= 1'b0;
              out_sign     <= acc_neg;
              out_scale    <= scale_d;
              out_fraction <= frac_d;
            end
          end
          OUT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              acc       <= '0;
              nar       <= 1'b0;
              state     <= ACCUM;
            end
          end
          default: state <= ACCUM;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_posit_quire_accum.sv
// Directed-vector bench for posit_quire_accum: stimulus pushes expected results, a monitor pops on each output handshake.
module tb_posit_quire_accum;
  localparam int MBITS  = 56;
  localparam int OFBITS = 31;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic              in_sign;
  logic [8:0]        in_scale;
  logic [MBITS-1:0]  in_fraction;
  logic              in_inf;
  logic              in_zero;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [9:0]        out_scale;
  logic [OFBITS-1:0] out_fraction;
  logic              out_inf;
  logic              out_zero;

  posit_quire_accum dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_sign(in_sign), .in_scale(in_scale), .in_fraction(in_fraction),
    .in_inf(in_inf), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_scale(out_scale), .out_fraction(out_fraction),
    .out_inf(out_inf), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    int          scale;
    logic [30:0] frac;
    logic        inf;
    logic        zero;
    bit          full;
    int          t;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic prev_vld = 1'b0;

  localparam logic [MBITS-1:0] ONE   = 56'h40000000000000;
  localparam logic [MBITS-1:0] ONEP5 = 56'h60000000000000;
  localparam logic [MBITS-1:0] TWO25 = 56'h90000000000000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", nm);
  endtask

  function automatic exp_t mk(input logic s, input int sc, input logic [30:0] f,
                              input logic inf, input logic zero, input bit full);
    exp_t e;
    e.sign = s; e.scale = sc; e.frac = f; e.inf = inf; e.zero = zero; e.full = full; e.t = 0;
    return e;
  endfunction

  // Monitor: latency on the rising edge of out_valid, field checks on the handshake.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_vld = 1'b0;
    end else begin
      if (out_valid && !prev_vld) begin
        if (exp_q.size() == 0) fail_now("unexpected_output");
        else chk("latency", cyc, exp_q[0].t + 4);
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_inf", out_inf, e.inf);
        chk("out_zero", out_zero, e.zero);
        if (e.full) begin
          chk("out_sign", out_sign, e.sign);
          chk("out_scale", $signed(out_scale), e.scale);
          chk("out_fraction", out_fraction, e.frac);
        end
      end
      prev_vld = out_valid;
    end
  end

  // Presents one beat; pushes e as the expected result when push is set and the beat is accepted.
  task automatic beat(input logic s, input int sc, input logic [MBITS-1:0] f,
                      input logic inf, input logic zero, input logic last,
                      input bit push, input exp_t e);
    bit ok = 0;
    in_valid = 1'b1; in_sign = s; in_scale = 9'(sc); in_fraction = f;
    in_inf = inf; in_zero = zero; in_last = last;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) fail_now("in_ready_wait");
    else begin
      exp_t ee;
      ee = e;
      ee.t = cyc;
      if (push) exp_q.push_back(ee);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0; in_last = 1'b0; in_inf = 1'b0; in_zero = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) ok = 1;
    end
    if (!ok) fail_now("drain_wait");
    @(posedge clk); #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t nx;
    nx = mk(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_sign = 1'b0;
    in_scale = '0; in_fraction = '0; in_inf = 1'b0; in_zero = 1'b0; out_ready = 1'b1;

    // Reset state and the one-cycle in_ready hold-off.
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_scale", out_scale, 0);
    chk("rst_out_inf", out_inf, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_first", in_ready, 0);
    @(negedge clk);
    chk("rst_in_ready_then", in_ready, 1);
    @(posedge clk); #1;

    // Four 1.0 -> 4.0
    for (int k = 0; k < 4; k++)
      beat(0, 0, ONE, 0, 0, k == 3, k == 3, mk(0, 2, 0, 0, 0, 1));
    wait_idle();

    // +1.5 - 1.5 -> exact zero
    beat(0, 0, ONEP5, 0, 0, 0, 0, nx);
    beat(1, 0, ONEP5, 0, 0, 1, 1, mk(0, 0, 0, 0, 1, 0));
    wait_idle();

    // NaR poisons the sum, then a clean one-term sum
    beat(0, 0, ONE, 0, 0, 0, 0, nx);
    beat(0, 0, '0, 1, 0, 0, 0, nx);
    beat(0, 0, ONE, 0, 0, 1, 1, mk(0, 0, 0, 1, 0, 1));
    wait_idle();
    beat(0, 0, ONE, 0, 0, 1, 1, mk(0, 0, 0, 0, 0, 1));
    wait_idle();

    // Extreme range, exact cancellation of the large terms
    beat(0, 240, ONE, 0, 0, 0, 0, nx);
    beat(0, -240, ONE, 0, 0, 0, 0, nx);
    beat(1, 240, ONE, 0, 0, 1, 1, mk(0, -240, 0, 0, 0, 1));
    wait_idle();

    // 1.5 + 1.5 = 3.0 ; single -1.5 ; 2.25 (product with integer bit 1)
    beat(0, 0, ONEP5, 0, 0, 0, 0, nx);
    beat(0, 0, ONEP5, 0, 0, 1, 1, mk(0, 1, 31'h40000000, 0, 0, 1));
    wait_idle();
    beat(1, 0, ONEP5, 0, 0, 1, 1, mk(1, 0, 31'h40000000, 0, 0, 1));
    wait_idle();
    beat(0, 0, TWO25, 0, 0, 1, 1, mk(0, 1, 31'h10000000, 0, 0, 1));
    wait_idle();

    // Truncation boundary: 2^-31 is the last kept bit, 2^-32 falls off; zero terms contribute nothing
    beat(0, 0, ONE | (56'd1 << 23), 0, 0, 1, 1, mk(0, 0, 31'd1, 0, 0, 1));
    wait_idle();
    beat(0, 0, ONE, 0, 1, 0, 0, nx);
    beat(0, 0, ONE | (56'd1 << 22), 0, 0, 1, 1, mk(0, 0, 31'd0, 0, 0, 1));
    wait_idle();

    // Backpressure: 5 stalled cycles, handshake in the 6th
    out_ready = 1'b0;
    beat(0, 0, ONEP5, 0, 0, 1, 1, mk(0, 0, 31'h40000000, 0, 0, 1));
    begin
      bit ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        if (out_valid) ok = 1;
      end
      if (!ok) fail_now("bp_valid_wait");
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_fraction", out_fraction, 31'h40000000);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_out_valid_after", out_valid, 0);
    @(posedge clk); #1;

    // clear mid-sum, with a beat dropped in the clear cycle
    beat(0, 0, ONE, 0, 0, 0, 0, nx);
    beat(0, 0, ONE, 0, 0, 0, 0, nx);
    clear = 1'b1; in_valid = 1'b1; in_fraction = ONE; in_scale = '0; in_last = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    beat(0, 1, ONE, 0, 0, 1, 1, mk(0, 1, 0, 0, 0, 1));
    wait_idle();

    // Reset during DRAIN: no result, outputs cleared, new sum works afterwards
    beat(0, 3, ONE, 0, 0, 1, 0, nx);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rstd_out_valid", out_valid, 0);
    chk("rstd_in_ready", in_ready, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rstd_no_output", out_valid, 0);
    end
    chk("rstd_out_scale", out_scale, 0);
    @(posedge clk); #1;
    beat(0, 0, ONE, 0, 0, 1, 1, mk(0, 0, 0, 0, 0, 1));
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
